// File: rtl/call_stack_if.sv
// Call-stack port bundle: push/pop/err_clr requests in, top-of-stack and status out.
interface call_stack_if #(
  parameter int PTR_W = 3
);
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [8:0]       stack_psh;
  logic [8:0]       stack_pop;
  logic [PTR_W:0]   level;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, err_clr, stack_psh,
    input  stack_pop, level, full, empty, ovf, unf
  );

  modport slave (
    input  push, pop, err_clr, stack_psh,
    output stack_pop, level, full, empty, ovf, unf
  );
endinterface

// File: rtl/call_stack.sv
// Hardware return-address stack (CALL/RETLW) built as a ring buffer with a
// saturating level counter and sticky overflow/underflow flags.
// Build option: CALL_STACK_OVF_TRAP_EN -- when defined, a push into a full
// stack is dropped; otherwise it overwrites the oldest entry circularly.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  call_stack_if.slave   bus
);

  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] TP_RST   = PTR_W'(DEPTH-1);

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] tp, tp_n, tp_inc, wr_idx;
  logic [PTR_W:0]   level, level_n;
  logic             ovf, unf, ovf_set, unf_set, wr_en;
  logic             is_empty, is_full;

  assign is_empty = (level == '0);
  assign is_full  = (level == LVL_FULL);
  // DEPTH is a power of two, so the natural wrap of tp is modulo DEPTH.
  assign tp_inc   = tp + 1'b1;

  // Next-state decode for the four push/pop combinations.
  always_comb begin
    tp_n    = tp;
    level_n = level;
    wr_en   = 1'b0;
    wr_idx  = tp_inc;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.push && bus.pop) begin
      if (!is_empty) begin
        // Tail call: replace the top in place.
        wr_en  = 1'b1;
        wr_idx = tp;
      end else begin
        // Nothing to discard: behave as a plain push, but flag the bad pop.
        tp_n    = tp_inc;
        wr_en   = 1'b1;
        level_n = level + 1'b1;
        unf_set = 1'b1;
      end
    end else if (bus.push) begin
      if (!is_full) begin
        tp_n    = tp_inc;
        wr_en   = 1'b1;
        level_n = level + 1'b1;
      end else begin
        ovf_set = 1'b1;
`ifdef CALL_STACK_OVF_TRAP_EN
        // Keep the existing entries intact; the push is dropped.
`else
        // Oldest entry is lost; level stays saturated at DEPTH.
        tp_n  = tp_inc;
        wr_en = 1'b1;
`endif
      end
    end else if (bus.pop) begin
      if (!is_empty) begin
        tp_n    = tp - 1'b1;
        level_n = level - 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  // State registers; reset wins over every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp    <= TP_RST;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      tp    <= tp_n;
      level <= level_n;
      // A new error in the clear cycle keeps the flag set.
      ovf   <= ovf_set | (ovf & ~bus.err_clr);
      unf   <= unf_set | (unf & ~bus.err_clr);
      if (wr_en) mem[wr_idx] <= bus.stack_psh;
    end
  end

  // Top of stack is visible the same cycle so RETLW needs no extra stage.
  assign bus.stack_pop = is_empty ? 9'h1FF : mem[tp];
  assign bus.level     = level;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.ovf       = ovf;
  assign bus.unf       = unf;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack at DEPTH=4; expected values are hand-computed.
module tb_call_stack;
  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;

  call_stack_if #(.PTR_W(2)) bus();

  call_stack #(.DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the currently driven inputs for one clock, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [8:0] d, input logic c);
    bus.push = p; bus.pop = q; bus.stack_psh = d; bus.err_clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 9'h000, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_top",   32'(bus.stack_pop), 32'h1FF);
    chk("rst_ovf",   32'(bus.ovf), 0);
    chk("rst_unf",   32'(bus.unf), 0);

    // Three pushes, then a pop
    drive(1'b1, 1'b0, 9'h010, 1'b0); step();
    chk("push1_top", 32'(bus.stack_pop), 32'h010);
    drive(1'b1, 1'b0, 9'h020, 1'b0); step();
    drive(1'b1, 1'b0, 9'h030, 1'b0); step();
    idle();
    chk("push3_level", 32'(bus.level), 3);
    chk("push3_top",   32'(bus.stack_pop), 32'h030);
    drive(1'b0, 1'b1, 9'h000, 1'b0);
    chk("pop_same_cycle_top", 32'(bus.stack_pop), 32'h030);
    step(); idle();
    chk("pop_top",   32'(bus.stack_pop), 32'h020);
    chk("pop_level", 32'(bus.level), 2);

    // Push+pop replaces the top
    drive(1'b1, 1'b1, 9'h0AA, 1'b0); step(); idle();
    chk("repl_top",   32'(bus.stack_pop), 32'h0AA);
    chk("repl_level", 32'(bus.level), 2);
    chk("repl_flags", 32'({bus.ovf, bus.unf}), 0);
    drive(1'b0, 1'b1, 9'h000, 1'b0); step(); idle();
    chk("repl_below", 32'(bus.stack_pop), 32'h010);
    chk("repl_below_level", 32'(bus.level), 1);

    // Reset together with push at level 3
    drive(1'b1, 1'b0, 9'h040, 1'b0); step();
    drive(1'b1, 1'b0, 9'h050, 1'b0); step();
    chk("pre_rst_level", 32'(bus.level), 3);
    rst = 1'b1; drive(1'b1, 1'b0, 9'h060, 1'b0); step();
    rst = 1'b0; idle();
    chk("rstpush_level", 32'(bus.level), 0);
    chk("rstpush_empty", 32'(bus.empty), 1);
    chk("rstpush_top",   32'(bus.stack_pop), 32'h1FF);
    chk("rstpush_flags", 32'({bus.ovf, bus.unf}), 0);

    // Pop on empty -> underflow, then clear
    drive(1'b0, 1'b1, 9'h000, 1'b0); step(); idle();
    chk("unf_set",   32'(bus.unf), 1);
    chk("unf_level", 32'(bus.level), 0);
    chk("unf_top",   32'(bus.stack_pop), 32'h1FF);
    drive(1'b0, 1'b0, 9'h000, 1'b1); step(); idle();
    chk("unf_clr", 32'(bus.unf), 0);

    // Push+pop on empty behaves as push and flags underflow
    drive(1'b1, 1'b1, 9'h077, 1'b0); step(); idle();
    chk("pp_empty_level", 32'(bus.level), 1);
    chk("pp_empty_top",   32'(bus.stack_pop), 32'h077);
    chk("pp_empty_unf",   32'(bus.unf), 1);

    // Overflow with five pushes from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 9'(i), 1'b0); step();
    end
    idle();
    chk("ovf_level", 32'(bus.level), 4);
    chk("ovf_full",  32'(bus.full), 1);
    chk("ovf_flag",  32'(bus.ovf), 1);
`ifdef CALL_STACK_OVF_TRAP_EN
    chk("ovf_top", 32'(bus.stack_pop), 32'h004);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 9'h000, 1'b0);
      chk("ovf_pop_seq", 32'(bus.stack_pop), 32'(4 - i));
      step();
    end
`else
    chk("ovf_top", 32'(bus.stack_pop), 32'h005);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 9'h000, 1'b0);
      chk("ovf_pop_seq", 32'(bus.stack_pop), 32'(5 - i));
      step();
    end
`endif
    idle();
    chk("ovf_drain_empty", 32'(bus.empty), 1);
    chk("ovf_drain_unf",   32'(bus.unf), 0);

    // err_clr in the same cycle as another overflow: flag stays set
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 9'(9'h100 + i), 1'b0); step();
    end
    drive(1'b1, 1'b0, 9'h1AB, 1'b1); step(); idle();
    chk("ovf_clr_race", 32'(bus.ovf), 1);
    chk("ovf_clr_race_level", 32'(bus.level), 4);
    drive(1'b0, 1'b0, 9'h000, 1'b1); step(); idle();
    chk("ovf_clr", 32'(bus.ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
